orig_img_server: RTL and testbench
==================================

ORIG_IMG_SERVER -- requirements
Module: orig_img_server

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset: clk in, rst_n in.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-004 host_valid  input  1  host byte valid during image load.
REQ-005 host_data  input  8  host pixel byte, raster order, address 0 first.
REQ-006 host_ready  output  1  block accepts host byte this cycle.
REQ-007 reload  input  1  single-cycle pulse that restarts the image load.
REQ-008 load_done  output  1  all 16384 pixels stored; serving enabled.
REQ-009 request  input  1  imgproc pixel request, level, held until orig_ready.
REQ-010 orig_addr  input  14  requested pixel address, stable while request high.
REQ-011 orig_data  output  8  returned pixel; holds its last value between responses.
REQ-012 orig_ready  output  1  one-cycle pulse; orig_data valid in that cycle.
REQ-013 sram_cen / sram_wen  output  1 each  active-low chip enable / write enable, 16384x8 single-port SRAM.
REQ-014 sram_addr  output  14; sram_d  output  8; sram_q  input  8 (read data valid the cycle after the read cycle).

Function
REQ-015 FSM states SHALL be LOAD, SERVE, RD, CAP; reset state LOAD.
REQ-016 In LOAD: host_ready=1; each host_valid&host_ready beat writes host_data to sram_addr=load_cnt (cen=0, wen=0) and increments load_cnt.
REQ-017 Beat with load_cnt=16383 SHALL set load_done=1, wrap load_cnt to 0, and enter SERVE next cycle.
REQ-018 In LOAD, request SHALL be ignored (no SRAM read, no orig_ready); imgproc keeps request high.
REQ-019 Outside LOAD: host_ready=0, host beats dropped.
REQ-020 SERVE, request=1, cache hit (cache_vld and orig_addr==cache_addr): orig_data<=cache_data, orig_ready=1 in the next cycle, stay SERVE.
REQ-021 SERVE, request=1, miss: latch orig_addr, go RD; RD drives cen=0, wen=1, sram_addr=latched address; CAP registers sram_q into orig_data and cache_data, sets cache_addr, cache_vld=1, orig_ready=1 in the cycle after CAP, returns to SERVE.
REQ-022 Miss latency: orig_ready SHALL be high exactly 3 cycles after the first cycle request is sampled high; hit latency 1 cycle.
REQ-023 SERVE SHALL not sample request in the cycle orig_ready is high; request still high in the following cycle is a new request.
REQ-024 orig_ready SHALL never be high on two consecutive cycles.
REQ-025 reload=1 in any state SHALL, next cycle: enter LOAD, clear load_done, load_cnt and cache_vld; an in-flight miss is abandoned with no orig_ready; reload has priority over request.
REQ-026 sram_cen=1 whenever no read or write is issued; no SRAM access in SERVE or CAP.
REQ-027 Address arithmetic 14-bit unsigned; no address beyond 16383 exists.

Reset
REQ-028 rst_n=0 at a rising edge SHALL set: state LOAD, load_cnt 0, load_done 0, cache_vld 0, orig_ready 0, orig_data 8'h00, host_ready 0 during reset cycle, sram_cen 1, sram_wen 1.
REQ-029 Reset mid-load or mid-miss SHALL discard progress; image must be reloaded from address 0.

Structure
REQ-030 Shared package imgproc_pkg SHALL hold IMG_W=128, IMG_PIX=16384, ADDR_W=14, DATA_W=8 and the state enum.
REQ-031 Single-entry hit cache SHALL be inline; no sub-module required; SRAM is external.

Verification
REQ-032 Load 16384 bytes data=addr[7:0], host_valid always 1 -> load_done rises 1 cycle after the 16384th beat; host_ready then 0.
REQ-033 request addr 0x1234 after load -> orig_ready 3 cycles later, orig_data=8'h34, single-cycle pulse.
REQ-034 request addr 0x1234 held high after response -> hit, orig_ready 2 cycles after previous pulse, data 8'h34, no sram_cen=0.
REQ-035 request high during LOAD (beat 100) -> no orig_ready until load_done, then miss served normally.
REQ-036 reload during RD of addr 5 -> no orig_ready, host_ready=1 next cycle, load_done=0, cache miss on next addr-5 request.
REQ-037 rst_n=0 for one cycle mid-load at beat 5000 -> all outputs at REQ-028 values, next load writes from address 0.

Source files
------------

// File: rtl/imgproc_pkg.sv
// Shared image geometry and server FSM encoding for the imgproc block family.
package imgproc_pkg;

    localparam int IMG_W   = 128;
    localparam int IMG_PIX = 16384;
    localparam int ADDR_W  = 14;
    localparam int DATA_W  = 8;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_PIX - 1);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SERVE = 2'd1,
        RD    = 2'd2,
        CAP   = 2'd3
    } srv_state_e;

endpackage

// File: rtl/orig_img_server.sv
// Loads a 128x128 image from the host into external SRAM, then serves single
// pixel reads to imgproc through a one-entry cache of the last fetched pixel.
module orig_img_server
    import imgproc_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              host_valid,
    input  logic [DATA_W-1:0] host_data,
    output logic              host_ready,
    input  logic              reload,
    output logic              load_done,
    input  logic              request,
    input  logic [ADDR_W-1:0] orig_addr,
    output logic [DATA_W-1:0] orig_data,
    output logic              orig_ready,
    output logic              sram_cen,
    output logic              sram_wen,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_d,
    input  logic [DATA_W-1:0] sram_q
);

    srv_state_e        state, state_nxt;
    logic [ADDR_W-1:0] load_cnt;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] cache_addr;
    logic [DATA_W-1:0] cache_data;
    logic              cache_vld;
    logic              beat;
    logic              hit;
    logic              miss;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= LOAD;
        else        state <= state_nxt;
    end

    // The cycle that carries orig_ready is skipped so a held request is
    // treated as a fresh one only from the following cycle.
    always_comb begin
        state_nxt  = state;
        host_ready = 1'b0;
        sram_cen   = 1'b1;
        sram_wen   = 1'b1;
        sram_addr  = load_cnt;
        sram_d     = host_data;
        beat       = 1'b0;
        hit        = 1'b0;
        miss       = 1'b0;
        case (state)
            LOAD: begin
                host_ready = rst_n;
                beat       = rst_n & host_valid;
                if (beat) begin
                    sram_cen = 1'b0;
                    sram_wen = 1'b0;
                    if (load_cnt == LAST_ADDR) state_nxt = SERVE;
                end
            end
            SERVE: begin
                if (request && !orig_ready) begin
                    if (cache_vld && (orig_addr == cache_addr)) begin
                        hit = 1'b1;
                    end else begin
                        miss      = 1'b1;
                        state_nxt = RD;
                    end
                end
            end
            RD: begin
                sram_cen  = ~rst_n;
                sram_addr = rd_addr;
                state_nxt = CAP;
            end
            CAP:     state_nxt = SERVE;
            default: state_nxt = LOAD;
        endcase
        if (reload) state_nxt = LOAD;
    end

    // Control and response registers; reload wins over any pending response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            load_cnt   <= '0;
            load_done  <= 1'b0;
            cache_vld  <= 1'b0;
            orig_ready <= 1'b0;
            orig_data  <= '0;
        end else begin
            orig_ready <= 1'b0;
            if (reload) begin
                load_cnt  <= '0;
                load_done <= 1'b0;
                cache_vld <= 1'b0;
            end else begin
                if (beat) begin
                    load_cnt <= load_cnt + ADDR_W'(1);
                    if (load_cnt == LAST_ADDR) load_done <= 1'b1;
                end
                if (hit) begin
                    orig_data  <= cache_data;
                    orig_ready <= 1'b1;
                end
                if (state == CAP) begin
                    orig_data  <= sram_q;
                    cache_vld  <= 1'b1;
                    orig_ready <= 1'b1;
                end
            end
        end
    end

    // Miss address and cache payload; validity lives in cache_vld above.
    always_ff @(posedge clk) begin
        if (miss) rd_addr <= orig_addr;
        if (state == CAP) begin
            cache_data <= sram_q;
            cache_addr <= rd_addr;
        end
    end

endmodule

// File: tb/tb_orig_img_server.sv
// Randomized bench for orig_img_server: behavioural SRAM, image/cache model,
// latency and data checks for loads, hits, misses, reload and reset.
module tb_orig_img_server;

    logic        clk;
    logic        rst_n;
    logic        host_valid;
    logic [7:0]  host_data;
    logic        host_ready;
    logic        reload;
    logic        load_done;
    logic        request;
    logic [13:0] orig_addr;
    logic [7:0]  orig_data;
    logic        orig_ready;
    logic        sram_cen;
    logic        sram_wen;
    logic [13:0] sram_addr;
    logic [7:0]  sram_d;
    logic [7:0]  sram_q;

    orig_img_server dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .host_valid (host_valid),
        .host_data  (host_data),
        .host_ready (host_ready),
        .reload     (reload),
        .load_done  (load_done),
        .request    (request),
        .orig_addr  (orig_addr),
        .orig_data  (orig_data),
        .orig_ready (orig_ready),
        .sram_cen   (sram_cen),
        .sram_wen   (sram_wen),
        .sram_addr  (sram_addr),
        .sram_d     (sram_d),
        .sram_q     (sram_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External single-port SRAM, read data one cycle after the read cycle.
    logic [7:0] mem [16384];
    always @(posedge clk) begin
        if (!sram_cen) begin
            if (!sram_wen) mem[sram_addr] <= sram_d;
            else           sram_q <= mem[sram_addr];
        end
    end

    // Reference model: image as the host sent it, plus the single cached address.
    logic [7:0]  img [16384];
    bit          m_vld;
    logic [13:0] m_addr;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            cyc();
            request    = 1'b0;
            host_valid = 1'b0;
            reload     = 1'b0;
            #1;
        end
    endtask

    // One request; here=1 means the current cycle already has it asserted.
    task automatic do_req(input logic [13:0] a, input string tag, input bit here);
        bit         got;
        bit         is_hit;
        int         lat;
        int         cen_low;
        int         bad_rd;
        logic [7:0] d;
        if (!here) begin
            cyc();
            request   = 1'b1;
            orig_addr = a;
            #1;
        end
        chk({tag, " rdy0"}, orig_ready, 0);
        cen_low = sram_cen ? 0 : 1;
        bad_rd  = 0;
        got     = 0;
        lat     = -1;
        d       = 8'h00;
        for (int k = 1; k <= 8 && !got; k++) begin
            cyc();
            #1;
            if (!sram_cen) begin
                cen_low++;
                if (sram_addr !== a || sram_wen !== 1'b1) bad_rd++;
            end
            if (orig_ready) begin
                got = 1;
                lat = k;
                d   = orig_data;
            end
        end
        is_hit = m_vld && (m_addr == a);
        chk({tag, " latency"}, lat, is_hit ? 1 : 3);
        chk({tag, " data"}, d, img[a]);
        chk({tag, " sram reads"}, cen_low, is_hit ? 0 : 1);
        chk({tag, " read addr"}, bad_rd, 0);
        m_vld  = 1;
        m_addr = a;
    endtask

    task automatic load_img(input int stop_at, input bit pat, input bit gaps,
                            input int req_at, input logic [13:0] ra);
        int         beat;
        int         cycles;
        int         bad_hr;
        int         bad_or;
        int         bad_ld;
        int         bad_wr;
        bit         hv;
        logic [7:0] hd;
        beat = 0; cycles = 0; bad_hr = 0; bad_or = 0; bad_ld = 0; bad_wr = 0;
        while (beat < stop_at && cycles < 40000) begin
            cyc();
            cycles++;
            hv = gaps ? ($urandom_range(0, 9) != 0) : 1'b1;
            hd = pat ? beat[7:0] : 8'($urandom);
            host_valid = hv;
            host_data  = hd;
            if (beat == req_at) begin
                request   = 1'b1;
                orig_addr = ra;
            end
            #1;
            if (host_ready !== 1'b1) bad_hr++;
            if (orig_ready !== 1'b0) bad_or++;
            if (load_done !== 1'b0)  bad_ld++;
            if (hv) begin
                if (sram_cen !== 1'b0 || sram_wen !== 1'b0 ||
                    sram_addr !== beat[13:0] || sram_d !== hd) bad_wr++;
                img[beat] = hd;
                beat++;
            end else if (sram_cen !== 1'b1) begin
                bad_wr++;
            end
        end
        chk("load beats", beat, stop_at);
        chk("load host_ready", bad_hr, 0);
        chk("load no orig_ready", bad_or, 0);
        chk("load load_done low", bad_ld, 0);
        chk("load sram writes", bad_wr, 0);
        if (stop_at == 16384) begin
            cyc();
            host_valid = 1'b1;
            host_data  = 8'hA5;
            #1;
            chk("load_done after last beat", load_done, 1);
            chk("host_ready after load", host_ready, 0);
            chk("no write after load", sram_cen, 1);
        end
    endtask

    task automatic rnd_phase(input int n);
        logic [13:0] a;
        logic [13:0] last;
        last = 14'd0;
        for (int i = 0; i < n; i++) begin
            a = ($urandom_range(0, 2) == 0) ? last : 14'($urandom_range(0, 16383));
            do_req(a, "rnd", 0);
            last = a;
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
        end
        idle(2);
    endtask

    initial begin
        rst_n      = 1'b0;
        host_valid = 1'b0;
        host_data  = 8'h00;
        reload     = 1'b0;
        request    = 1'b0;
        orig_addr  = 14'd0;
        m_vld      = 0;
        m_addr     = 14'd0;

        cyc();
        cyc();
        chk("rst host_ready", host_ready, 0);
        chk("rst sram_cen", sram_cen, 1);
        chk("rst sram_wen", sram_wen, 1);
        chk("rst orig_ready", orig_ready, 0);
        chk("rst orig_data", orig_data, 8'h00);
        chk("rst load_done", load_done, 0);
        cyc();
        rst_n = 1'b1;
        #1;
        chk("load host_ready", host_ready, 1);

        // Pattern load; imgproc raises a request for 0x1234 at beat 100.
        load_img(16384, 1, 0, 100, 14'h1234);
        do_req(14'h1234, "first miss", 1);
        chk("pix 1234", orig_data, 8'h34);
        do_req(14'h1234, "held hit", 0);
        idle(2);
        rnd_phase(60);

        // Reload while the miss for address 5 is in its SRAM read cycle.
        do_req(14'd6, "pre reload", 0);
        idle(2);
        cyc();
        request   = 1'b1;
        orig_addr = 14'd5;
        #1;
        cyc();
        reload = 1'b1;
        #1;
        chk("rd cycle cen", sram_cen, 0);
        cyc();
        reload = 1'b0;
        #1;
        chk("reload host_ready", host_ready, 1);
        chk("reload load_done", load_done, 0);
        chk("reload orig_ready", orig_ready, 0);
        m_vld = 0;
        load_img(16384, 0, 1, -1, 14'd5);
        do_req(14'd5, "miss after reload", 1);
        idle(2);
        rnd_phase(40);

        // Reset in the middle of a load.
        cyc();
        reload = 1'b1;
        #1;
        cyc();
        reload = 1'b0;
        #1;
        load_img(5000, 0, 0, -1, 14'd0);
        cyc();
        rst_n      = 1'b0;
        host_valid = 1'b1;
        host_data  = 8'h5A;
        #1;
        chk("mid rst host_ready", host_ready, 0);
        chk("mid rst sram_cen", sram_cen, 1);
        chk("mid rst sram_wen", sram_wen, 1);
        cyc();
        rst_n      = 1'b1;
        host_valid = 1'b0;
        #1;
        chk("mid rst orig_ready", orig_ready, 0);
        chk("mid rst orig_data", orig_data, 8'h00);
        chk("mid rst load_done", load_done, 0);
        chk("mid rst host_ready after", host_ready, 1);
        m_vld = 0;
        load_img(16384, 0, 0, -1, 14'd0);
        idle(1);
        do_req(14'd0, "addr0 after reset", 0);
        do_req(14'd16383, "last addr", 0);
        idle(1);
        rnd_phase(100);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
